// File: rtl/phase_display_sequencer.sv
// Phase sequencer for the clock project: walks section 1, banner, section 2, done,
// and owns the shared 4-digit seven-segment display and its anode scan.
module phase_display_sequencer #(
    parameter int SCAN_DIV      = 100000,
    parameter int BANNER_CYCLES = 200000000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        p1_done,
    input  logic        p2_done,
    input  logic [31:0] p1_seg,
    input  logic [3:0]  p1_mask,
    input  logic [31:0] p2_seg,
    input  logic [3:0]  p2_mask,
    input  logic [31:0] banner_seg,
    output logic        p1_en,
    output logic        p2_en,
    output logic [2:0]  state,
    output logic        first_done,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int BAN_W  = $clog2(BANNER_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BAN_W-1:0]  BAN_LAST  = BAN_W'(BANNER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P1     = 3'd1,
        S_BANNER = 3'd2,
        S_P2     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_r;
    logic [BAN_W-1:0]   ban_cnt;
    logic [SCAN_W-1:0]  scan_cnt_p0;
    logic [1:0]         digit_p0;
    logic [31:0]        sel_seg_p0;
    logic [3:0]         sel_mask_p0;

    function automatic logic [3:0] anode_low(input logic [1:0] d);
        anode_low = ~(4'b0001 << d);
    endfunction

    assign state = state_r;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r    <= S_IDLE;
            p1_en      <= 1'b0;
            p2_en      <= 1'b0;
            first_done <= 1'b0;
            ban_cnt    <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_P1;
                    p1_en   <= 1'b1;
                end
                S_P1: begin
                    if (p1_done) begin
                        state_r    <= S_BANNER;
                        p1_en      <= 1'b0;
                        first_done <= 1'b1;
                        ban_cnt    <= '0;
                    end
                end
                S_BANNER: begin
                    // Counter holds the number of edges already spent in BANNER.
                    if (ban_cnt == BAN_LAST) begin
                        state_r <= S_P2;
                        p2_en   <= 1'b1;
                        ban_cnt <= '0;
                    end else begin
                        ban_cnt <= ban_cnt + 1'b1;
                    end
                end
                S_P2: begin
                    if (p2_done) begin
                        state_r <= S_DONE;
                        p2_en   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                    p1_en   <= 1'b0;
                    p2_en   <= 1'b0;
                end
            endcase
        end
    end

    // Scan runs continuously; phase changes never restart it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scan_cnt_p0 <= '0;
            digit_p0    <= 2'd0;
        end else if (scan_cnt_p0 == SCAN_LAST) begin
            scan_cnt_p0 <= '0;
            digit_p0    <= digit_p0 + 2'd1;
        end else begin
            scan_cnt_p0 <= scan_cnt_p0 + 1'b1;
        end
    end

    always_comb begin
        sel_seg_p0  = 32'hFFFF_FFFF;
        sel_mask_p0 = 4'b0000;
        case (state_r)
            S_P1: begin
                sel_seg_p0  = p1_seg;
                sel_mask_p0 = p1_mask;
            end
            S_BANNER: begin
                sel_seg_p0  = banner_seg;
                sel_mask_p0 = 4'b1111;
            end
            S_P2, S_DONE: begin
                sel_seg_p0  = p2_seg;
                sel_mask_p0 = p2_mask;
            end
            default: begin
                sel_seg_p0  = 32'hFFFF_FFFF;
                sel_mask_p0 = 4'b0000;
            end
        endcase
    end

    // Stage p0 -> output register: one digit at most, blank when masked off.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end else if (sel_mask_p0[digit_p0]) begin
            an  <= anode_low(digit_p0);
            seg <= sel_seg_p0[{digit_p0, 3'b000} +: 8];
        end else begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_phase_display_sequencer.sv
// Scoreboard bench for phase_display_sequencer: a cycle model pushes expected
// outputs before each edge, and they are popped and compared after it.
module tb_phase_display_sequencer;

    localparam int SCAN_DIV      = 4;
    localparam int BANNER_CYCLES = 10;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        p1_done = 1'b0;
    logic        p2_done = 1'b0;
    logic [31:0] p1_seg = 32'hFFFF_FFC0;
    logic [3:0]  p1_mask = 4'b0001;
    logic [31:0] p2_seg = 32'h8899_A4F9;
    logic [3:0]  p2_mask = 4'hF;
    logic [31:0] banner_seg = 32'h92B0_A4F9;
    logic        p1_en, p2_en, first_done;
    logic [2:0]  state;
    logic [7:0]  seg;
    logic [3:0]  an;

    phase_display_sequencer #(.SCAN_DIV(SCAN_DIV), .BANNER_CYCLES(BANNER_CYCLES)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .p1_done(p1_done), .p2_done(p2_done),
        .p1_seg(p1_seg), .p1_mask(p1_mask), .p2_seg(p2_seg), .p2_mask(p2_mask),
        .banner_seg(banner_seg), .p1_en(p1_en), .p2_en(p2_en), .state(state),
        .first_done(first_done), .seg(seg), .an(an)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [2:0] st;
        logic       p1e;
        logic       p2e;
        logic       fd;
        logic [7:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [2:0] m_st = 3'd0;
    int m_scan = 0, m_idx = 0, m_ban = 0;
    logic m_fd = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic [3:0] msk;
        logic [31:0] sb;
        logic [2:0] nst;
        if (RESET) begin
            nst = 3'd0; m_scan = 0; m_idx = 0; m_ban = 0; m_fd = 1'b0;
            e.seg = 8'hFF; e.an = 4'hF;
        end else begin
            case (m_st)
                3'd1:       begin msk = p1_mask; sb = p1_seg; end
                3'd2:       begin msk = 4'hF;    sb = banner_seg; end
                3'd3, 3'd4: begin msk = p2_mask; sb = p2_seg; end
                default:    begin msk = 4'h0;    sb = 32'hFFFF_FFFF; end
            endcase
            if (msk[m_idx]) begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = sb[8*m_idx +: 8];
            end else begin
                e.an  = 4'hF;
                e.seg = 8'hFF;
            end
            nst = m_st;
            case (m_st)
                3'd0: nst = 3'd1;
                3'd1: if (p1_done) begin nst = 3'd2; m_fd = 1'b1; m_ban = 0; end
                3'd2: begin
                    if (m_ban == BANNER_CYCLES - 1) begin nst = 3'd3; m_ban = 0; end
                    else m_ban++;
                end
                3'd3: if (p2_done) nst = 3'd4;
                default: nst = 3'd4;
            endcase
            if (m_scan == SCAN_DIV - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
            else m_scan++;
        end
        e.st  = nst;
        e.p1e = (nst == 3'd1);
        e.p2e = (nst == 3'd3);
        e.fd  = m_fd;
        m_st  = nst;
        q.push_back(e);
        @(posedge CLOCK);
        #1;
        e = q.pop_front();
        check("state", {29'd0, state}, {29'd0, e.st});
        check("p1_en", {31'd0, p1_en}, {31'd0, e.p1e});
        check("p2_en", {31'd0, p2_en}, {31'd0, e.p2e});
        check("first_done", {31'd0, first_done}, {31'd0, e.fd});
        check("seg", {24'd0, seg}, {24'd0, e.seg});
        check("an", {28'd0, an}, {28'd0, e.an});
    endtask

    task automatic run_until(input logic [2:0] target, input int max, input string tag);
        int n = 0;
        while (state !== target && n < max) begin
            tick();
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, target});
    endtask

    task automatic banner_len(input string tag);
        int n = 0;
        while (state === 3'd2 && n < 50) begin
            tick();
            n++;
        end
        check(tag, n, BANNER_CYCLES);
    endtask

    task automatic wait_an(input logic [3:0] pat, input int max, output int n);
        n = 0;
        while (an !== pat && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, lit;
        // Reset state
        repeat (3) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {24'd0, seg}, 32'hFF);

        // 1: release, P1 with digit 0 only
        RESET = 1'b0;
        tick();
        check("s1_state", {29'd0, state}, 32'd1);
        check("s1_p1en", {31'd0, p1_en}, 32'd1);
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (an === 4'b1110 && seg === 8'hC0) lit++;
        end
        check("s1_lit_cycles", lit, 8);

        // 2: p1_done pulse, banner, then P2
        p1_done = 1'b1;
        tick();
        p1_done = 1'b0;
        check("s2_state", {29'd0, state}, 32'd2);
        check("s2_first_done", {31'd0, first_done}, 32'd1);
        banner_len("s2_banner_len");
        check("s2_p2en", {31'd0, p2_en}, 32'd1);

        // 5: blank digit 2 mid-slot, scan keeps advancing
        wait_an(4'b1101, 20, n);
        wait_an(4'b1011, 20, n);
        check("s5_digit2", {28'd0, an}, 32'hB);
        p2_mask = 4'h0;
        tick();
        check("s5_blank_an", {28'd0, an}, 32'hF);
        check("s5_blank_seg", {24'd0, seg}, 32'hFF);
        p2_mask = 4'hF;
        wait_an(4'b0111, 20, n);
        check("s5_digit3_delay", n + 1, 4);

        // DONE keeps tracking live p2 inputs
        p2_done = 1'b1;
        tick();
        p2_done = 1'b0;
        check("done_state", {29'd0, state}, 32'd4);
        for (int i = 0; i < 12; i++) begin
            p2_seg = $urandom;
            p2_mask = 4'($urandom_range(0, 15));
            tick();
        end
        p2_mask = 4'hF;

        // 3: p2_done held through P1 and BANNER
        RESET = 1'b1; tick(); RESET = 1'b0;
        p2_done = 1'b1;
        tick();
        repeat (3) tick();
        check("s3_still_p1", {29'd0, state}, 32'd1);
        p1_done = 1'b1; tick(); p1_done = 1'b0;
        run_until(3'd3, 30, "s3_reach_p2");
        tick();
        check("s3_done", {29'd0, state}, 32'd4);
        check("s3_p2en", {31'd0, p2_en}, 32'd0);
        p2_done = 1'b0;
        p2_seg = 32'h1234_5678;
        repeat (6) tick();

        // 4: reset mid-banner, full sequence repeats
        RESET = 1'b1; tick(); RESET = 1'b0;
        run_until(3'd1, 5, "s4_p1");
        p1_done = 1'b1; tick(); p1_done = 1'b0;
        repeat (5) tick();
        RESET = 1'b1; tick();
        check("s4_rst_state", {29'd0, state}, 32'd0);
        check("s4_rst_fd", {31'd0, first_done}, 32'd0);
        check("s4_rst_an", {28'd0, an}, 32'hF);
        check("s4_rst_seg", {24'd0, seg}, 32'hFF);
        RESET = 1'b0;
        run_until(3'd1, 5, "s4_p1_again");
        p1_done = 1'b1; tick(); p1_done = 1'b0;
        banner_len("s4_banner_len");

        // 6: both done inputs in P1
        RESET = 1'b1; tick(); RESET = 1'b0;
        run_until(3'd1, 5, "s6_p1");
        p1_done = 1'b1; p2_done = 1'b1;
        tick();
        p1_done = 1'b0; p2_done = 1'b0;
        check("s6_state", {29'd0, state}, 32'd2);
        check("s6_fd", {31'd0, first_done}, 32'd1);
        check("s6_p2en", {31'd0, p2_en}, 32'd0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
